multicycle_adder: RTL and testbench

//  Parametrised sequential adder: computes a + b + cin on WIDTH-bit operands,

---
 rtl/multicycle_adder_pkg.sv | 20 ++
 rtl/multicycle_adder_chunk.sv | 42 ++++
 rtl/multicycle_adder.sv | 141 ++++++++++++++
 tb/tb_multicycle_adder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/multicycle_adder_pkg.sv
// Shared types and elaboration helpers for the multicycle adder.
// Imported by the top level and its chunk datapath.
package multicycle_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    // Number of ADD cycles per transaction. A zero CHUNK is caught by the
    // top-level parameter check, so it returns 1 to keep elaboration going.
    function automatic int nchunk(input int width, input int chunk);
        if (chunk <= 0) begin
            return 1;
        end
        return width / chunk;
    endfunction

endpackage

// File: rtl/multicycle_adder_chunk.sv
// Full-adder cell and the CHUNK-bit ripple adder built from it; this is the
// only arithmetic in the multicycle adder and is reused every ADD cycle.
module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        fa u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (s[i]),
            .co (carry[i+1])
        );
    end

    assign cout = carry[CHUNK];

endmodule

// File: rtl/multicycle_adder.sv
// Sequential adder: a + b + cin on WIDTH bits, CHUNK bits per clock through a
// registered carry, with valid/ready on both sides and a held result.
module multicycle_adder
    import multicycle_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int CW     = $clog2(NCHUNK + 1);

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("multicycle_adder: CHUNK must be 1..WIDTH and divide WIDTH");
    end

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [CHUNK-1:0]       chunk_s;
    logic                   chunk_cout;
    logic [WIDTH+CHUNK-1:0] sum_ext;

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a    (a_q[CHUNK-1:0]),
        .b    (b_q[CHUNK-1:0]),
        .cin  (carry_q),
        .s    (chunk_s),
        .cout (chunk_cout)
    );

    // New chunk enters from the top; this form stays legal when CHUNK == WIDTH.
    assign sum_ext = {chunk_s, sum_q};

    always_comb begin
        // NOTE: every *_d gets its hold value first so no path infers a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                sum_d   = sum_ext[WIDTH+CHUNK-1:CHUNK];
                carry_d = chunk_cout;
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(NCHUNK - 1)) begin
                    // The last chunk carries the sum MSB, so flags resolve here.
                    cout_d  = chunk_cout;
                    ovf_d   = (a_msb_q == b_msb_q) && (chunk_s[CHUNK-1] != a_msb_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // NOTE: operand/carry registers are always loaded on accept before use,
    // so they carry no reset.
    always_ff @(posedge clk) begin
        a_q     <= a_d;
        b_q     <= b_d;
        carry_q <= carry_d;
        a_msb_q <= a_msb_d;
        b_msb_q <= b_msb_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Directed bench for multicycle_adder in three shapes: W16/C4, W4/C1 (full
// sweep) and W8/C8; expected values are hand-computed or from a small model.
module tb_multicycle_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    // W16 / C4
    logic        iv16 = 0, ir16, ov16, or16 = 0, ci16 = 0, co16, of16;
    logic [15:0] a16 = 0, b16 = 0, s16;
    // W4 / C1
    logic        iv4 = 0, ir4, ov4, or4 = 0, ci4 = 0, co4, of4;
    logic [3:0]  a4 = 0, b4 = 0, s4;
    // W8 / C8
    logic        iv8 = 0, ir8, ov8, or8 = 0, ci8 = 0, co8, of8;
    logic [7:0]  a8 = 0, b8 = 0, s8;

    multicycle_adder #(.WIDTH(16), .CHUNK(4)) u16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .cin(ci16), .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .ovf(of16)
    );
    multicycle_adder #(.WIDTH(4), .CHUNK(1)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .cin(ci4), .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4), .ovf(of4)
    );
    multicycle_adder #(.WIDTH(8), .CHUNK(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .cin(ci8), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(of8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edge count starts at 1 on the edge that samples the handshake.
    task automatic run16(input string tag, input logic [15:0] a_v, input logic [15:0] b_v,
                         input logic c_v, input logic [17:0] exp_res);
        int lat;
        check({tag, " in_ready idle"}, 32'(ir16), 32'd1);
        iv16 = 1'b1; a16 = a_v; b16 = b_v; ci16 = c_v;
        tick();
        iv16 = 1'b0; a16 = 16'hDEAD; b16 = 16'hBEEF; ci16 = 1'b1;
        check({tag, " in_ready busy"}, 32'(ir16), 32'd0);
        lat = 1;
        while (!ov16 && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd5);
        check({tag, " result"}, 32'({of16, co16, s16}), 32'(exp_res));
        or16 = 1'b1;
        tick();
        or16 = 1'b0;
        check({tag, " back to idle"}, 32'({ir16, ov16}), 32'b10);
    endtask

    initial begin
        int          lat;
        logic [4:0]  ref_sum;
        logic        ref_ovf;
        logic [17:0] held;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("reset in_ready", 32'({ir16, ir4, ir8}), 32'b111);
        check("reset out_valid", 32'({ov16, ov4, ov8}), 32'b000);
        check("reset result16", 32'({of16, co16, s16}), 32'd0);

        // Basic W16/C4 vectors: {ovf, cout, sum}
        run16("carry across chunk", 16'h00FF, 16'h0001, 1'b0, {1'b0, 1'b0, 16'h0100});
        run16("wrap unsigned", 16'hFFFF, 16'h0001, 1'b0, {1'b0, 1'b1, 16'h0000});
        run16("pos overflow", 16'h7FFF, 16'h0000, 1'b1, {1'b1, 1'b0, 16'h8000});
        run16("neg overflow", 16'h8000, 16'h8000, 1'b0, {1'b1, 1'b1, 16'h0000});
        run16("plain add cin", 16'h1234, 16'h4321, 1'b1, {1'b0, 1'b0, 16'h5556});

        // Back-pressure: result held while out_ready is low
        iv16 = 1'b1; a16 = 16'h1234; b16 = 16'h1111; ci16 = 1'b0;
        tick();
        iv16 = 1'b0;
        lat = 1;
        while (!ov16 && lat < 40) begin
            tick();
            lat++;
        end
        check("bp latency", 32'(lat), 32'd5);
        held = {of16, co16, s16};
        check("bp result", 32'(held), 32'({1'b0, 1'b0, 16'h2345}));
        for (int k = 0; k < 6; k++) begin
            tick();
            check("bp hold result", 32'({of16, co16, s16}), 32'({1'b0, 1'b0, 16'h2345}));
            check("bp hold handshake", 32'({ir16, ov16}), 32'b01);
        end
        or16 = 1'b1;
        tick();
        or16 = 1'b0;
        check("bp release", 32'({ir16, ov16}), 32'b10);

        // Reset during the second ADD cycle
        iv16 = 1'b1; a16 = 16'h0F0F; b16 = 16'h0101; ci16 = 1'b0;
        tick();
        iv16 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid reset handshake", 32'({ir16, ov16}), 32'b10);
        check("mid reset result", 32'({of16, co16, s16}), 32'd0);
        run16("after reset", 16'h1234, 16'hEDCC, 1'b0, {1'b0, 1'b1, 16'h0000});

        // W8/C8: one ADD cycle
        iv8 = 1'b1; a8 = 8'h80; b8 = 8'h80; ci8 = 1'b0;
        tick();
        iv8 = 1'b0;
        lat = 1;
        while (!ov8 && lat < 20) begin
            tick();
            lat++;
        end
        check("w8 latency", 32'(lat), 32'd2);
        check("w8 result", 32'({of8, co8, s8}), 32'({1'b1, 1'b1, 8'h00}));
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
        check("w8 back to idle", 32'({ir8, ov8}), 32'b10);

        // W4/C1 exhaustive sweep with random gaps and out_ready noise
        for (int v = 0; v < 512; v++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                tick();
            end
            check("w4 ready", 32'(ir4), 32'd1);
            {ci4, a4, b4} = 9'(v);
            ref_sum = 5'(a4) + 5'(b4) + 5'(ci4);
            ref_ovf = (a4[3] == b4[3]) && (ref_sum[3] != a4[3]);
            iv4 = 1'b1;
            tick();
            iv4 = 1'b0;
            lat = 1;
            while (!ov4 && lat < 20) begin
                or4 = 1'($urandom_range(0, 1));
                tick();
                lat++;
            end
            or4 = 1'b0;
            check("w4 latency", 32'(lat), 32'd5);
            check("w4 result", 32'({of4, co4, s4}), 32'({ref_ovf, ref_sum}));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                tick();
            end
            or4 = 1'b1;
            tick();
            or4 = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
